// File: rtl/lift_pkg.sv
// Shared encodings and helpers for the lift scan scheduler.
package lift_pkg;

  localparam int unsigned FLOOR_W = 3;
  localparam int unsigned DIR_W   = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_IDLE = 2'b00;
  localparam dir_t DIR_UP   = 2'b01;
  localparam dir_t DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  // SCAN choice: keep the preferred sweep if work lies that way, else reverse.
  // An idle preference sweeps up first.
  function automatic dir_t pick_dir(input dir_t pref, input logic any_up, input logic any_down);
    dir_t d;
    d = DIR_IDLE;
    if (pref == DIR_DOWN) begin
      if (any_down)    d = DIR_DOWN;
      else if (any_up) d = DIR_UP;
    end else begin
      if (any_up)        d = DIR_UP;
      else if (any_down) d = DIR_DOWN;
    end
    return d;
  endfunction

endpackage

// File: rtl/lift_dwell_timer.sv
// Down-counter shared by travel and door dwell; done while the count is zero.
module lift_dwell_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                       count_q <= '0;
    else if (load)                    count_q <= value;
    else if (tick && count_q != '0)   count_q <= count_q - W'(1);
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lift_scan_scheduler.sv
// Single-car SCAN scheduler: latches calls, sequences travel and door dwell,
// and owns the car's floor and direction.
module lift_scan_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 3,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_call,
  input  logic [NUM_FLOORS-1:0] cab_call,
  input  logic                  door_obstruct,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [DIR_W-1:0]      direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived
);

  localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, step_floor;
  dir_t                    dir_q, dir_d, pick;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [NUM_FLOORS-1:0]   req, here_bit, step_bit, above_mask, below_mask, served;
  logic                    req_here, req_above, req_below, step_hit, at_limit;
  logic                    moving_q, door_q, arrived_q;
  logic                    tmr_load, tmr_tick, tmr_done;
  logic [TMR_W-1:0]        tmr_value;

  lift_dwell_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .tick  (tmr_tick),
    .done  (tmr_done)
  );

  // Request view relative to the car: here, above, below, and the next floor in travel.
  always_comb begin
    req        = pending_q | hall_call | cab_call;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (FLOOR_W'(i) > floor_q);
      below_mask[i] = (FLOOR_W'(i) < floor_q);
    end
    here_bit   = NUM_FLOORS'(1) << floor_q;
    step_floor = (dir_q == DIR_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    step_bit   = NUM_FLOORS'(1) << step_floor;
    req_here   = |(req & here_bit);
    req_above  = |(req & above_mask);
    req_below  = |(req & below_mask);
    step_hit   = |(req & step_bit);
    at_limit   = ((dir_q == DIR_UP)   && (floor_q == TOP_FLOOR)) ||
                 ((dir_q == DIR_DOWN) && (floor_q == '0)) ||
                 (dir_q == DIR_IDLE);
  end

  // Next-state, timer control and request clearing.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    tmr_value = TRAVEL_LOAD;
    pick      = pick_dir(dir_q, req_above, req_below);

    unique case (state_q)
      ST_IDLE: begin
        dir_d = DIR_IDLE;
        if (req_here) begin
          state_d   = ST_DOOR;
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (pick != DIR_IDLE) begin
          state_d  = ST_MOVE;
          dir_d    = pick;
          tmr_load = 1'b1;
        end
      end
      ST_MOVE: begin
        tmr_tick = 1'b1;
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!at_limit) begin
            floor_d = step_floor;
            if (step_hit) begin
              state_d   = ST_DOOR;
              tmr_value = DOOR_LOAD;
            end
          end
        end
      end
      ST_DOOR: begin
        tmr_tick = 1'b1;
        if (door_obstruct || req_here) begin
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (tmr_done) begin
          if (pick != DIR_IDLE) begin
            state_d  = ST_MOVE;
            dir_d    = pick;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            dir_d   = DIR_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The door floor is served in the arrival cycle too, so a same-cycle call is absorbed.
    served = '0;
    if (state_q == ST_DOOR || state_d == ST_DOOR) served = NUM_FLOORS'(1) << floor_d;
    pending_d = req & ~served;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_IDLE;
      pending_q <= '0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      moving_q  <= (state_d == ST_MOVE);
      door_q    <= (state_d == ST_DOOR);
      arrived_q <= (state_d == ST_DOOR) && (state_q != ST_DOOR);
    end
  end

  assign pending       = pending_q;
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_q;
  assign arrived       = arrived_q;

  // The car must never be asked to step past the end floors.
  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == ST_MOVE && tmr_done && at_limit));
  a_floor_range: assert property (@(posedge clk) disable iff (!rst_n)
    floor_q <= TOP_FLOOR);

endmodule

// File: tb/tb_lift_scan_scheduler.sv
// Directed bench for lift_scan_scheduler with a cycle-level behavioural model.
module tb_lift_scan_scheduler;

  localparam int NF = 3;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] hall_call = '0;
  logic [NF-1:0] cab_call = '0;
  logic          door_obstruct = 1'b0;
  logic [NF-1:0] pending;
  logic [2:0]    current_floor;
  logic [1:0]    direction;
  logic          moving, door_open, arrived;

  lift_scan_scheduler #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hall_call(hall_call), .cab_call(cab_call),
    .door_obstruct(door_obstruct), .pending(pending), .current_floor(current_floor),
    .direction(direction), .moving(moving), .door_open(door_open), .arrived(arrived)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 idle, 1 travelling, 2 door; dir -1/0/+1; cnt = cycles left in segment.
  int m_floor = 0, m_dir = 0, m_mode = 0, m_cnt = 0;
  bit m_arr = 1'b0;
  bit m_pend [NF];

  always @(posedge clk) begin : model
    bit r [NF];
    bit up, dn;
    int served, pref;
    if (!rst_n) begin
      m_floor = 0; m_dir = 0; m_mode = 0; m_cnt = 0; m_arr = 1'b0;
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    end else begin
      up = 1'b0; dn = 1'b0; served = -1; m_arr = 1'b0;
      for (int i = 0; i < NF; i++) begin
        r[i] = m_pend[i] | hall_call[i] | cab_call[i];
        if (r[i] && i > m_floor) up = 1'b1;
        if (r[i] && i < m_floor) dn = 1'b1;
      end
      case (m_mode)
        0: begin
          if (r[m_floor]) begin
            m_mode = 2; m_cnt = DC; m_arr = 1'b1; served = m_floor;
          end else if (up) begin
            m_mode = 1; m_dir = 1; m_cnt = TC;
          end else if (dn) begin
            m_mode = 1; m_dir = -1; m_cnt = TC;
          end else m_dir = 0;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_floor = m_floor + m_dir;
            if (r[m_floor]) begin
              m_mode = 2; m_cnt = DC; m_arr = 1'b1; served = m_floor;
            end else m_cnt = TC;
          end
        end
        default: begin
          served = m_floor;
          if (door_obstruct || r[m_floor]) m_cnt = DC;
          else begin
            m_cnt--;
            if (m_cnt == 0) begin
              pref = (m_dir < 0) ? -1 : 1;
              if ((pref > 0 && up) || (pref < 0 && dn)) begin
                m_mode = 1; m_dir = pref; m_cnt = TC;
              end else if ((pref > 0 && dn) || (pref < 0 && up)) begin
                m_mode = 1; m_dir = -pref; m_cnt = TC;
              end else begin
                m_mode = 0; m_dir = 0;
              end
            end
          end
        end
      endcase
      for (int i = 0; i < NF; i++) m_pend[i] = r[i] && (i != served);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dir_code(input int d);
    return (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b00;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NF-1:0] exp_pend;
    if (cmp_en) begin
      for (int i = 0; i < NF; i++) exp_pend[i] = m_pend[i];
      check("pending", 8'(pending), 8'(exp_pend));
      check("floor", 8'(current_floor), 8'(m_floor));
      check("direction", 8'(direction), 8'(dir_code(m_dir)));
      check("moving", 8'(moving), 8'(m_mode == 1));
      check("door_open", 8'(door_open), 8'(m_mode == 2));
      check("arrived", 8'(arrived), 8'(m_arr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((moving || door_open) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic wait_door(input int budget);
    int n = 0;
    while (!door_open && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_door: door closed after %0d cycles, required open", budget);
    end
  endtask

  task automatic call(input logic [NF-1:0] hall, input logic [NF-1:0] cab);
    hall_call = hall; cab_call = cab;
    tick(1);
    hall_call = '0; cab_call = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    check("rst_floor", 8'(current_floor), 8'd0);
    check("rst_pending", 8'(pending), 8'd0);
    check("rst_dir", 8'(direction), 8'd0);
    check("rst_moving", 8'(moving), 8'd0);
    check("rst_door", 8'(door_open), 8'd0);
    check("rst_arrived", 8'(arrived), 8'd0);
    rst_n = 1'b1;
    tick(1);

    // Call at the car's own floor opens the door without motion.
    call('0, 3'b001);
    check("t1_door", 8'(door_open), 8'd1);
    check("t1_moving", 8'(moving), 8'd0);
    check("t1_dir", 8'(direction), 8'd0);
    check("t1_pending", 8'(pending), 8'd0);
    tick(2);
    check("t1_door_last", 8'(door_open), 8'd1);
    tick(1);
    check("t1_door_closed", 8'(door_open), 8'd0);

    // Full two-floor run up.
    call(3'b100, '0);
    check("t2_moving", 8'(moving), 8'd1);
    check("t2_dir", 8'(direction), 8'd1);
    check("t2_pending", 8'(pending), 8'b100);
    tick(3);
    check("t2_floor0", 8'(current_floor), 8'd0);
    tick(1);
    check("t2_floor1", 8'(current_floor), 8'd1);
    tick(4);
    check("t2_floor2", 8'(current_floor), 8'd2);
    check("t2_arrived", 8'(arrived), 8'd1);
    check("t2_pend_clr", 8'(pending), 8'd0);
    tick(3);
    check("t2_idle_door", 8'(door_open), 8'd0);
    check("t2_idle_dir", 8'(direction), 8'd0);

    // Tie at floor 1: up first, then reverse.
    call('0, 3'b010);
    wait_idle(40);
    check("t3_at1", 8'(current_floor), 8'd1);
    call(3'b101, '0);
    check("t3_dir_up", 8'(direction), 8'd1);
    check("t3_pending", 8'(pending), 8'b101);
    wait_idle(60);
    check("t3_end_floor", 8'(current_floor), 8'd0);
    check("t3_end_pend", 8'(pending), 8'd0);

    // Obstruction holds the door 5 + 3 cycles.
    call('0, 3'b010);
    wait_door(40);
    door_obstruct = 1'b1;
    tick(5);
    door_obstruct = 1'b0;
    tick(2);
    check("t4_door_held", 8'(door_open), 8'd1);
    tick(1);
    check("t4_door_closed", 8'(door_open), 8'd0);

    // Call behind the car during travel is latched and served on the return.
    call('0, 3'b001);
    wait_idle(40);
    call(3'b100, '0);
    tick(2);
    call('0, 3'b001);
    check("t5_latched", 8'(pending), 8'b101);
    check("t5_floor", 8'(current_floor), 8'd0);
    wait_idle(80);
    check("t5_end_floor", 8'(current_floor), 8'd0);
    check("t5_end_pend", 8'(pending), 8'd0);

    // Reset between floors aborts everything.
    call(3'b100, '0);
    tick(6);
    check("t6_mid_floor", 8'(current_floor), 8'd1);
    rst_n = 1'b0;
    cab_call = 3'b010;
    tick(1);
    check("t6_floor", 8'(current_floor), 8'd0);
    check("t6_moving", 8'(moving), 8'd0);
    check("t6_pending", 8'(pending), 8'd0);
    check("t6_dir", 8'(direction), 8'd0);
    cab_call = '0;
    rst_n = 1'b1;
    tick(1);

    // Fresh call at the arrival floor in the arrival cycle is served.
    call(3'b100, '0);
    tick(7);
    check("t7_floor1", 8'(current_floor), 8'd1);
    call('0, 3'b100);
    check("t7_floor2", 8'(current_floor), 8'd2);
    check("t7_arrived", 8'(arrived), 8'd1);
    check("t7_pending", 8'(pending), 8'd0);
    wait_idle(20);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
